// File: rtl/fx2_cmd_parser_if.sv
// Bundle for the FX2 command parser: command byte stream, framed reply and 32-bit register bus.
// The slave modport is the parser's view; master is the host/bridge side.
interface fx2_cmd_parser_if;
  logic [7:0]  cmd;
  logic        cmd_wr;
  logic [7:0]  reply;
  logic        reply_rdy;
  logic        reply_ack;
  logic        reply_end;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        reply_overrun;

  modport master (
    output cmd, cmd_wr, reply_ack, reg_rdata,
    input  reply, reply_rdy, reply_end, reg_addr, reg_wdata, reg_wr, reg_rd, reply_overrun
  );

  modport slave (
    input  cmd, cmd_wr, reply_ack, reg_rdata,
    output reply, reply_rdy, reply_end, reg_addr, reg_wdata, reg_wr, reg_rd, reply_overrun
  );
endinterface

// File: rtl/fx2_cmd_parser.sv
// Decodes framed register read/write commands from the FX2 byte stream onto a 32-bit
// register bus and returns read data (or an error byte) as a framed byte reply.
module fx2_cmd_parser #(
  parameter int unsigned TIMEOUT = 1023,
  parameter logic [7:0]  MAGIC   = 8'hAA
) (
  input logic           fx2_clk,
  input logic           reset,
  fx2_cmd_parser_if.slave bus
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned RB_N  = 5;
  localparam int unsigned IDX_W = 3;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_OP      = 4'd1;
  localparam logic [3:0] S_ADDR_W  = 4'd2;
  localparam logic [3:0] S_D0      = 4'd3;
  localparam logic [3:0] S_D1      = 4'd4;
  localparam logic [3:0] S_D2      = 4'd5;
  localparam logic [3:0] S_D3      = 4'd6;
  localparam logic [3:0] S_EXEC_WR = 4'd7;
  localparam logic [3:0] S_ADDR_R  = 4'd8;
  localparam logic [3:0] S_EXEC_RD = 4'd9;
  localparam logic [3:0] S_CAPT    = 4'd10;

  logic [3:0]       state, state_nxt;
  logic [TO_W-1:0]  tmo_cnt;
  logic             byte_state, timed_out;
  logic             reg_wr_nxt, reg_rd_nxt, addr_we, load_rd, load_err, overrun_set;
  logic [3:0]       data_we;

  logic [7:0]       reg_addr_q;
  logic [31:0]      reg_wdata_q;
  logic             reg_wr_q, reg_rd_q, overrun_q;

  logic [7:0]       rbuf [RB_N];
  logic [IDX_W-1:0] idx, len;
  logic             rdy_q;

  // Only byte-consuming states can be abandoned by the idle timeout.
  assign byte_state = (state == S_OP) || (state == S_ADDR_W) || (state == S_D0) ||
                      (state == S_D1) || (state == S_D2) || (state == S_D3) ||
                      (state == S_ADDR_R);
  assign timed_out  = byte_state && !bus.cmd_wr && (tmo_cnt >= TO_W'(TIMEOUT - 1));

  always_ff @(posedge fx2_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    reg_wr_nxt  = 1'b0;
    reg_rd_nxt  = 1'b0;
    addr_we     = 1'b0;
    data_we     = 4'b0000;
    load_rd     = 1'b0;
    load_err    = 1'b0;
    overrun_set = 1'b0;
    case (state)
      S_IDLE: if (bus.cmd_wr && bus.cmd == MAGIC) state_nxt = S_OP;
      S_OP: if (bus.cmd_wr) begin
        if (bus.cmd == 8'h01)      state_nxt = S_ADDR_W;
        else if (bus.cmd == 8'h02) state_nxt = S_ADDR_R;
        else begin
          state_nxt = S_IDLE;
          if (rdy_q) overrun_set = 1'b1;
          else       load_err    = 1'b1;
        end
      end
      S_ADDR_W: if (bus.cmd_wr) begin addr_we = 1'b1; state_nxt = S_D0; end
      S_D0: if (bus.cmd_wr) begin data_we[0] = 1'b1; state_nxt = S_D1; end
      S_D1: if (bus.cmd_wr) begin data_we[1] = 1'b1; state_nxt = S_D2; end
      S_D2: if (bus.cmd_wr) begin data_we[2] = 1'b1; state_nxt = S_D3; end
      S_D3: if (bus.cmd_wr) begin
        data_we[3] = 1'b1;
        reg_wr_nxt = 1'b1;
        state_nxt  = S_EXEC_WR;
      end
      S_EXEC_WR: state_nxt = S_IDLE;
      S_ADDR_R: if (bus.cmd_wr) begin
        if (rdy_q) begin
          overrun_set = 1'b1;
          state_nxt   = S_IDLE;
        end else begin
          addr_we    = 1'b1;
          reg_rd_nxt = 1'b1;
          state_nxt  = S_EXEC_RD;
        end
      end
      S_EXEC_RD: state_nxt = S_CAPT;
      S_CAPT: begin load_rd = 1'b1; state_nxt = S_IDLE; end
      default: state_nxt = S_IDLE;
    endcase
    if (timed_out) state_nxt = S_IDLE;
  end

  // Register bus outputs, sticky overrun, saturating idle counter and reply control.
  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 32'h0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      overrun_q   <= 1'b0;
      tmo_cnt     <= '0;
      idx         <= '0;
      len         <= '0;
      rdy_q       <= 1'b0;
    end else begin
      reg_wr_q <= reg_wr_nxt;
      reg_rd_q <= reg_rd_nxt;
      if (addr_we) reg_addr_q <= bus.cmd;
      for (int i = 0; i < 4; i++)
        if (data_we[i]) reg_wdata_q[8*i +: 8] <= bus.cmd;
      if (overrun_set) overrun_q <= 1'b1;

      if (bus.cmd_wr)
        tmo_cnt <= '0;
      else if (state != S_IDLE && tmo_cnt != TO_W'(TIMEOUT))
        tmo_cnt <= tmo_cnt + TO_W'(1);

      // A new load takes priority over an ack of the final byte.
      if (load_rd) begin
        idx   <= '0;
        len   <= IDX_W'(RB_N);
        rdy_q <= 1'b1;
      end else if (load_err) begin
        idx   <= '0;
        len   <= IDX_W'(1);
        rdy_q <= 1'b1;
      end else if (bus.reply_ack && rdy_q) begin
        if (idx == len - IDX_W'(1)) begin
          idx   <= '0;
          rdy_q <= 1'b0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge fx2_clk) begin
    if (load_rd) begin
      rbuf[0] <= reg_addr_q;
      rbuf[1] <= bus.reg_rdata[7:0];
      rbuf[2] <= bus.reg_rdata[15:8];
      rbuf[3] <= bus.reg_rdata[23:16];
      rbuf[4] <= bus.reg_rdata[31:24];
    end else if (load_err) begin
      rbuf[0] <= 8'hEE;
    end
  end

  assign bus.reply         = rdy_q ? rbuf[idx] : 8'h00;
  assign bus.reply_end     = rdy_q && (idx == len - IDX_W'(1));
  assign bus.reply_rdy     = rdy_q;
  assign bus.reg_addr      = reg_addr_q;
  assign bus.reg_wdata     = reg_wdata_q;
  assign bus.reg_wr        = reg_wr_q;
  assign bus.reg_rd        = reg_rd_q;
  assign bus.reply_overrun = overrun_q;

endmodule

// File: tb/tb_fx2_cmd_parser.sv
// Scoreboard bench for fx2_cmd_parser: stimulus pushes expected strobes and reply bytes,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_fx2_cmd_parser;
  localparam int unsigned TIMEOUT = 1023;

  logic fx2_clk = 1'b0;
  logic reset;
  always #5 fx2_clk = ~fx2_clk;

  fx2_cmd_parser_if bus();

  fx2_cmd_parser #(.TIMEOUT(TIMEOUT), .MAGIC(8'hAA)) dut (
    .fx2_clk (fx2_clk),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        wr_q [$];
  logic [7:0] rd_q [$];
  logic [8:0] rp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  bit ack_random = 1'b0;
  int ack_budget = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got unexpected event %0h, none expected", name, act);
  endtask

  // Reply consumer: random stalls, or a fixed number of acks.
  initial begin
    bus.reply_ack = 1'b0;
    forever begin
      @(posedge fx2_clk);
      #1;
      if (ack_random) bus.reply_ack = 1'($urandom_range(0, 1));
      else if (ack_budget > 0 && bus.reply_rdy) begin
        bus.reply_ack = 1'b1;
        ack_budget--;
      end else bus.reply_ack = 1'b0;
    end
  end

  // Monitor: compare every strobe and every consumed reply byte against the queues.
  initial begin
    forever begin
      @(negedge fx2_clk);
      if (mon_en && !reset) begin
        if (bus.reg_wr) begin
          if (wr_q.size() == 0) unexpected("reg_wr", 64'({bus.reg_addr, bus.reg_wdata}));
          else chk("reg_wr addr/data", 64'({bus.reg_addr, bus.reg_wdata}), 64'(wr_q.pop_front()));
        end
        if (bus.reg_rd) begin
          if (rd_q.size() == 0) unexpected("reg_rd", 64'(bus.reg_addr));
          else chk("reg_rd addr", 64'(bus.reg_addr), 64'(rd_q.pop_front()));
        end
        if (bus.reply_rdy && bus.reply_ack) begin
          if (rp_q.size() == 0) unexpected("reply", 64'({bus.reply_end, bus.reply}));
          else chk("reply {end,byte}", 64'({bus.reply_end, bus.reply}), 64'(rp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge fx2_clk);
    #1;
    bus.cmd    = b;
    bus.cmd_wr = 1'b1;
  endtask

  task automatic stop_cmd();
    @(posedge fx2_clk);
    #1;
    bus.cmd_wr = 1'b0;
    bus.cmd    = 8'h00;
  endtask

  task automatic write_frame(input logic [7:0] addr, input logic [31:0] data, input int gap);
    wr_q.push_back({addr, data});
    send_byte(8'hAA); send_byte(8'h01); send_byte(addr);
    for (int i = 0; i < 4; i++) begin
      if (gap > 0 && i == 2) begin
        stop_cmd();
        repeat (gap - 1) @(posedge fx2_clk);
      end
      send_byte(data[8*i +: 8]);
    end
    stop_cmd();
  endtask

  task automatic read_frame(input logic [7:0] addr, input logic [31:0] rdata, input bit accepted);
    bus.reg_rdata = rdata;
    if (accepted) begin
      rd_q.push_back(addr);
      rp_q.push_back({1'b0, addr});
      rp_q.push_back({1'b0, rdata[7:0]});
      rp_q.push_back({1'b0, rdata[15:8]});
      rp_q.push_back({1'b0, rdata[23:16]});
      rp_q.push_back({1'b1, rdata[31:24]});
    end
    send_byte(8'hAA); send_byte(8'h02); send_byte(addr);
    stop_cmd();
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((wr_q.size() + rd_q.size() + rp_q.size() != 0 || bus.reply_rdy) && t < 400) begin
      @(posedge fx2_clk);
      t++;
    end
    repeat (4) @(posedge fx2_clk);
    @(negedge fx2_clk);
    chk({name, " pending events"}, 64'(wr_q.size() + rd_q.size() + rp_q.size()), 64'd0);
    chk({name, " reply_rdy idle"}, 64'(bus.reply_rdy), 64'd0);
  endtask

  task automatic check_zero(input string name);
    chk(name, 64'({bus.reply, bus.reply_rdy, bus.reply_end, bus.reg_addr, bus.reg_wdata,
                   bus.reg_wr, bus.reg_rd, bus.reply_overrun}), 64'd0);
  endtask

  initial begin
    int t;
    reset         = 1'b1;
    bus.cmd       = 8'h00;
    bus.cmd_wr    = 1'b0;
    bus.reg_rdata = 32'h0;
    repeat (3) @(posedge fx2_clk);
    @(negedge fx2_clk);
    check_zero("reset outputs");
    @(posedge fx2_clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // Back-to-back write, then a write with a short mid-frame gap.
    write_frame(8'h10, 32'h12345678, 0);
    drain("write");
    write_frame(8'h3C, 32'hA5A55A5A, 20);
    drain("write gap");

    // Read with randomly stalled acks.
    ack_random = 1'b1;
    read_frame(8'h05, 32'hDEADBEEF, 1'b1);
    drain("read");

    // Garbage, bad opcode, then a valid frame.
    rp_q.push_back(9'h1EE);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hAA); send_byte(8'h07);
    stop_cmd();
    drain("bad opcode");
    write_frame(8'h22, 32'hCAFEF00D, 0);
    drain("after garbage");
    chk("overrun clear", 64'(bus.reply_overrun), 64'd0);

    // Partial write abandoned after exactly TIMEOUT idle cycles; following read works.
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10);
    stop_cmd();
    repeat (TIMEOUT - 1) @(posedge fx2_clk);
    read_frame(8'h10, 32'h0BADF00D, 1'b1);
    drain("timeout");

    // Two reads and a bad opcode without acks: only the first produces anything.
    ack_random = 1'b0;
    read_frame(8'h31, 32'h11223344, 1'b1);
    t = 0;
    while (!bus.reply_rdy && t < 50) begin @(posedge fx2_clk); t++; end
    chk("first reply ready", 64'(bus.reply_rdy), 64'd1);
    read_frame(8'h32, 32'h55667788, 1'b0);
    send_byte(8'hAA); send_byte(8'h07);
    stop_cmd();
    repeat (5) @(posedge fx2_clk);
    @(negedge fx2_clk);
    chk("overrun set", 64'(bus.reply_overrun), 64'd1);
    chk("first reply head", 64'({bus.reply_rdy, bus.reply_end, bus.reply}), 64'({2'b10, 8'h31}));
    ack_random = 1'b1;
    drain("overrun");
    chk("overrun sticky", 64'(bus.reply_overrun), 64'd1);
    ack_random = 1'b0;

    // Reset mid-frame.
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h78);
    @(posedge fx2_clk);
    #1;
    reset      = 1'b1;
    bus.cmd_wr = 1'b0;
    @(posedge fx2_clk);
    @(negedge fx2_clk);
    check_zero("reset mid-frame");
    @(posedge fx2_clk);
    #1 reset = 1'b0;

    // Reset mid-reply after two bytes consumed.
    read_frame(8'h40, 32'h87654321, 1'b1);
    ack_budget = 2;
    t = 0;
    while (ack_budget > 0 && t < 60) begin @(posedge fx2_clk); t++; end
    @(negedge fx2_clk);
    chk("mid reply byte 2", 64'({bus.reply_rdy, bus.reply_end, bus.reply}), 64'({2'b10, 8'h43}));
    @(posedge fx2_clk);
    #1 reset = 1'b1;
    @(posedge fx2_clk);
    @(negedge fx2_clk);
    check_zero("reset mid-reply");
    rp_q.delete();
    @(posedge fx2_clk);
    #1 reset = 1'b0;
    write_frame(8'h77, 32'h0F1E2D3C, 0);
    drain("post reset write");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
